rf_wr_arbiter: RTL and testbench

RF_WR_ARBITER -- requirements
Module: rf_wr_arbiter

---
 rtl/rf_wr_arbiter.sv | 188 ++++++++++++++++++
 tb/tb_rf_wr_arbiter.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/rf_wr_arbiter.sv
// -----------------------------------------------------------------------------
// rf_wr_arbiter
//
// Arbitrates the single register-file write port between the pipeline
// writeback (port A, no backpressure, always wins) and a long-latency unit
// (port B: load returns, divider). Port B results are parked in a small FIFO
// and drain on cycles where A does not write. An A write to a register kills
// every older buffered B result for that register, so the newer value is never
// overwritten. Killed entries still hold a slot and pop with rf_we=0.
//
// Optional feature (macro RF_ARB_FAIRNESS_EN): starvation control. If the
// buffer head waits STARVE_LIMIT cycles without popping, stall_req is raised
// for one cycle to ask the pipeline for a bubble.
//
// Parameters
//   DEPTH         B buffer entries (power of two, 2..4)
//   STARVE_LIMIT  waiting cycles before stall_req (fairness build only)
//
// Ports
//   clk, rst                     clock, synchronous active-high reset
//   a_we/a_waddr/a_wdata         pipeline writeback request
//   b_valid/b_waddr/b_wdata      long-latency result push
//   b_ready                      B may push this cycle
//   rf_we/rf_waddr/rf_wdata      register-file write port
//   chk_addr1/chk_addr2          ID-stage source registers
//   pend_hit                     a source register has a live buffered write
//   stall_req                    bubble request so B can drain
//   fifo_count                   entries held (live and killed)
// -----------------------------------------------------------------------------
module rf_wr_arbiter #(
    parameter int DEPTH        = 2,
    parameter int STARVE_LIMIT = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        a_we,
    input  logic [4:0]  a_waddr,
    input  logic [31:0] a_wdata,
    input  logic        b_valid,
    input  logic [4:0]  b_waddr,
    input  logic [31:0] b_wdata,
    output logic        b_ready,
    output logic        rf_we,
    output logic [4:0]  rf_waddr,
    output logic [31:0] rf_wdata,
    input  logic [4:0]  chk_addr1,
    input  logic [4:0]  chk_addr2,
    output logic        pend_hit,
    output logic        stall_req,
    output logic [2:0]  fifo_count
);

    localparam int         PTR_W   = (DEPTH > 2) ? $clog2(DEPTH) : 1;
    localparam logic [2:0] DEPTH_C = 3'(DEPTH);

    // Buffer storage: address/data plus a live bit per slot.
    logic [4:0]       r_waddr [DEPTH];
    logic [31:0]      r_wdata [DEPTH];
    logic [DEPTH-1:0] r_live;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [PTR_W-1:0] r_wr_ptr;
    logic [2:0]       r_count;

    logic w_a_req;
    logic w_empty;
    logic w_pop;
    logic w_space;
    logic w_push;
    logic w_pend;

    // Writes to r0 are architectural no-ops and never compete for the port.
    assign w_a_req = a_we && (a_waddr != 5'd0);
    assign w_empty = (r_count == 3'd0);
    assign w_pop   = !w_a_req && !w_empty;
    // Acceptance looks only at registered occupancy, never at a same-cycle pop.
    assign w_space = (r_count < DEPTH_C);
    assign w_push  = b_valid && w_space && (b_waddr != 5'd0);

    assign b_ready    = !rst && w_space;
    assign fifo_count = rst ? 3'd0 : r_count;

    // NOTE: every output of a combinational block gets a default first so no
    // path leaves it unassigned (which would infer a latch).
    always_comb begin
        rf_we    = 1'b0;
        rf_waddr = 5'd0;
        rf_wdata = 32'd0;
        if (!rst) begin
            if (w_a_req) begin
                rf_we    = 1'b1;
                rf_waddr = a_waddr;
                rf_wdata = a_wdata;
            end else if (w_pop) begin
                // A killed head still pops, it just does not write.
                rf_we    = r_live[r_rd_ptr];
                rf_waddr = r_waddr[r_rd_ptr];
                rf_wdata = r_wdata[r_rd_ptr];
            end
        end
    end

    always_comb begin
        w_pend = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (r_live[i] &&
                (((chk_addr1 != 5'd0) && (r_waddr[i] == chk_addr1)) ||
                 ((chk_addr2 != 5'd0) && (r_waddr[i] == chk_addr2)))) begin
                w_pend = 1'b1;
            end
        end
    end

    assign pend_hit = !rst && w_pend;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_live   <= '0;
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= 3'd0;
        end else begin
            // Squash older buffered results for the register A is writing.
            if (w_a_req) begin
                for (int i = 0; i < DEPTH; i++) begin
                    if (r_waddr[i] == a_waddr) begin
                        r_live[i] <= 1'b0;
                    end
                end
            end
            if (w_pop) begin
                r_live[r_rd_ptr] <= 1'b0;
                r_rd_ptr         <= r_rd_ptr + 1'b1;
            end
            // Placed after the squash so a same-cycle push to that register
            // lands live: it is newer than the A write.
            if (w_push) begin
                r_live[r_wr_ptr] <= 1'b1;
                r_wr_ptr         <= r_wr_ptr + 1'b1;
            end
            r_count <= r_count + {2'b00, w_push} - {2'b00, w_pop};
        end
    end

    // NOTE: payload storage is not reset; the live bits and count decide
    // what is meaningful, so resetting the array would only cost flops.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_waddr[r_wr_ptr] <= b_waddr;
            r_wdata[r_wr_ptr] <= b_wdata;
        end
    end

`ifdef RF_ARB_FAIRNESS_EN
    localparam int                CNT_W    = $clog2(STARVE_LIMIT + 1);
    localparam logic [CNT_W-1:0]  LIMIT_M1 = CNT_W'(STARVE_LIMIT - 1);

    logic [CNT_W-1:0] r_starve_cnt;
    logic             r_stall_req;

    // Counts cycles in which the head exists but A took the port. Reaching
    // the limit raises a one-cycle bubble request and restarts the count.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_starve_cnt <= '0;
            r_stall_req  <= 1'b0;
        end else begin
            r_stall_req <= 1'b0;
            if (!w_empty && !w_pop) begin
                if (r_starve_cnt == LIMIT_M1) begin
                    r_starve_cnt <= '0;
                    r_stall_req  <= 1'b1;
                end else begin
                    r_starve_cnt <= r_starve_cnt + 1'b1;
                end
            end else begin
                r_starve_cnt <= '0;
            end
        end
    end

    assign stall_req = !rst && r_stall_req;
`else
    assign stall_req = 1'b0;
`endif

endmodule

// File: tb/tb_rf_wr_arbiter.sv
// -----------------------------------------------------------------------------
// tb_rf_wr_arbiter
//
// Self-checking bench for rf_wr_arbiter: a table of directed per-cycle vectors,
// hand-written starvation sequences, then randomized traffic compared against
// a queue-based reference model. Inputs change on the falling edge; outputs
// are compared 1 ns later, well away from the rising edge.
// -----------------------------------------------------------------------------
module tb_rf_wr_arbiter;

    localparam int DEPTH        = 2;
    localparam int STARVE_LIMIT = 8;
`ifdef RF_ARB_FAIRNESS_EN
    localparam bit FAIR = 1'b1;
`else
    localparam bit FAIR = 1'b0;
`endif

    logic        clk;
    logic        rst;
    logic        a_we;
    logic [4:0]  a_waddr;
    logic [31:0] a_wdata;
    logic        b_valid;
    logic [4:0]  b_waddr;
    logic [31:0] b_wdata;
    logic        b_ready;
    logic        rf_we;
    logic [4:0]  rf_waddr;
    logic [31:0] rf_wdata;
    logic [4:0]  chk_addr1;
    logic [4:0]  chk_addr2;
    logic        pend_hit;
    logic        stall_req;
    logic [2:0]  fifo_count;

    rf_wr_arbiter #(
        .DEPTH        (DEPTH),
        .STARVE_LIMIT (STARVE_LIMIT)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .a_we       (a_we),
        .a_waddr    (a_waddr),
        .a_wdata    (a_wdata),
        .b_valid    (b_valid),
        .b_waddr    (b_waddr),
        .b_wdata    (b_wdata),
        .b_ready    (b_ready),
        .rf_we      (rf_we),
        .rf_waddr   (rf_waddr),
        .rf_wdata   (rf_wdata),
        .chk_addr1  (chk_addr1),
        .chk_addr2  (chk_addr2),
        .pend_hit   (pend_hit),
        .stall_req  (stall_req),
        .fifo_count (fifo_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_pass  = 0;
    int n_total = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    endtask

    task automatic set_in(input logic r, input logic aw, input logic [4:0] aa,
                          input logic [31:0] ad, input logic bv, input logic [4:0] ba,
                          input logic [31:0] bd, input logic [4:0] c1, input logic [4:0] c2);
        rst = r; a_we = aw; a_waddr = aa; a_wdata = ad;
        b_valid = bv; b_waddr = ba; b_wdata = bd;
        chk_addr1 = c1; chk_addr2 = c2;
    endtask

    // One directed cycle: inputs plus the outputs expected in that cycle.
    typedef struct {
        logic        rst, a_we, b_valid;
        logic [4:0]  a_addr, b_addr, c1, c2;
        logic [31:0] a_data, b_data;
        logic        e_we, e_brdy, e_pend;
        logic [4:0]  e_addr;
        logic [31:0] e_data;
        logic [2:0]  e_cnt;
    } vec_t;

    function automatic vec_t mk(int r, int aw, int aa, int ad, int bv, int ba, int bd,
                                int c1, int c2, int ewe, int ea, int ed, int ebr,
                                int epd, int ecnt);
        vec_t v;
        v.rst = 1'(r); v.a_we = 1'(aw); v.a_addr = 5'(aa); v.a_data = 32'(ad);
        v.b_valid = 1'(bv); v.b_addr = 5'(ba); v.b_data = 32'(bd);
        v.c1 = 5'(c1); v.c2 = 5'(c2);
        v.e_we = 1'(ewe); v.e_addr = 5'(ea); v.e_data = 32'(ed);
        v.e_brdy = 1'(ebr); v.e_pend = 1'(epd); v.e_cnt = 3'(ecnt);
        return v;
    endfunction

    vec_t vecs[$];

    typedef struct {
        logic [4:0]  addr;
        logic [31:0] data;
        bit          live;
    } ent_t;

    ent_t q[$];
    int   waits;
    bit   m_stall;

    initial begin
        set_in(1'b1, 0, 0, 0, 0, 0, 0, 0, 0);

        //                 rst aw aa  ad     bv ba  bd     c1  c2   we ea  ed     br pd cnt
        vecs.push_back(mk(1, 0, 0,  0,     0, 0,  0,     0,  0,   0, 0,  0,     0, 0, 0)); // in reset
        vecs.push_back(mk(0, 0, 0,  0,     0, 0,  0,     0,  0,   0, 0,  0,     1, 0, 0)); // first cycle out
        vecs.push_back(mk(0, 1, 5,  'h11,  0, 0,  0,     0,  0,   1, 5,  'h11,  1, 0, 0)); // A r5
        vecs.push_back(mk(0, 0, 0,  0,     1, 7,  'hAA,  7,  0,   0, 0,  0,     1, 0, 0)); // push r7
        vecs.push_back(mk(0, 0, 0,  0,     1, 8,  'hBB,  7,  8,   1, 7,  'hAA,  1, 1, 1)); // push r8, pop r7
        vecs.push_back(mk(0, 0, 0,  0,     0, 0,  0,     7,  8,   1, 8,  'hBB,  1, 1, 1)); // pop r8
        vecs.push_back(mk(0, 0, 0,  0,     0, 0,  0,     7,  8,   0, 0,  0,     1, 0, 0)); // empty
        vecs.push_back(mk(0, 1, 1,  5,     1, 10, 'hC,   0,  0,   1, 1,  5,     1, 0, 0)); // A busy, push
        vecs.push_back(mk(0, 1, 2,  6,     1, 11, 'hD,   0,  0,   1, 2,  6,     1, 0, 1)); // A busy, push
        vecs.push_back(mk(0, 1, 3,  7,     0, 0,  0,     10, 0,   1, 3,  7,     0, 1, 2)); // full, no pop
        vecs.push_back(mk(0, 0, 0,  0,     0, 0,  0,     11, 0,   1, 10, 'hC,   0, 1, 2)); // pop r10
        vecs.push_back(mk(0, 0, 0,  0,     0, 0,  0,     0,  0,   1, 11, 'hD,   1, 0, 1)); // pop r11
        vecs.push_back(mk(0, 0, 0,  0,     0, 0,  0,     0,  0,   0, 0,  0,     1, 0, 0));
        vecs.push_back(mk(0, 0, 0,  0,     1, 9,  1,     9,  0,   0, 0,  0,     1, 0, 0)); // push r9=1
        vecs.push_back(mk(0, 1, 9,  2,     0, 0,  0,     9,  0,   1, 9,  2,     1, 1, 1)); // A r9=2 squashes
        vecs.push_back(mk(0, 0, 0,  0,     0, 0,  0,     9,  0,   0, 9,  1,     1, 0, 1)); // killed pop
        vecs.push_back(mk(0, 0, 0,  0,     0, 0,  0,     9,  0,   0, 0,  0,     1, 0, 0));
        vecs.push_back(mk(0, 0, 0,  0,     1, 0,  'h55,  0,  0,   0, 0,  0,     1, 0, 0)); // push r0
        vecs.push_back(mk(0, 0, 0,  0,     0, 0,  0,     0,  0,   0, 0,  0,     1, 0, 0)); // not enqueued
        vecs.push_back(mk(0, 0, 0,  0,     1, 12, 'h21,  0,  12,  0, 0,  0,     1, 0, 0)); // push r12
        vecs.push_back(mk(0, 1, 12, 'h22,  1, 12, 'h23,  0,  12,  1, 12, 'h22,  1, 1, 1)); // squash + push
        vecs.push_back(mk(0, 0, 0,  0,     0, 0,  0,     0,  12,  0, 12, 'h21,  0, 1, 2)); // killed pop
        vecs.push_back(mk(0, 0, 0,  0,     0, 0,  0,     0,  12,  1, 12, 'h23,  1, 1, 1)); // live pop
        vecs.push_back(mk(0, 0, 0,  0,     0, 0,  0,     0,  12,  0, 0,  0,     1, 0, 0));
        vecs.push_back(mk(0, 1, 1,  9,     1, 13, 'h31,  0,  0,   1, 1,  9,     1, 0, 0)); // fill
        vecs.push_back(mk(0, 1, 1,  9,     1, 14, 'h32,  0,  0,   1, 1,  9,     1, 0, 1));
        vecs.push_back(mk(0, 1, 1,  9,     0, 0,  0,     13, 14,  1, 1,  9,     0, 1, 2)); // full
        vecs.push_back(mk(1, 0, 0,  0,     0, 0,  0,     13, 14,  0, 0,  0,     0, 0, 0)); // reset mid-drain
        vecs.push_back(mk(0, 0, 0,  0,     0, 0,  0,     13, 14,  0, 0,  0,     1, 0, 0)); // discarded
        vecs.push_back(mk(0, 0, 0,  0,     0, 0,  0,     0,  0,   0, 0,  0,     1, 0, 0));

        // ---------------- directed vector table ----------------
        foreach (vecs[i]) begin
            @(negedge clk);
            set_in(vecs[i].rst, vecs[i].a_we, vecs[i].a_addr, vecs[i].a_data, vecs[i].b_valid,
                   vecs[i].b_addr, vecs[i].b_data, vecs[i].c1, vecs[i].c2);
            #1;
            check($sformatf("vec%0d rf_we", i), 32'(rf_we), 32'(vecs[i].e_we));
            if (!vecs[i].rst) begin
                check($sformatf("vec%0d rf_waddr", i), 32'(rf_waddr), 32'(vecs[i].e_addr));
                check($sformatf("vec%0d rf_wdata", i), rf_wdata, vecs[i].e_data);
            end
            check($sformatf("vec%0d b_ready", i), 32'(b_ready), 32'(vecs[i].e_brdy));
            check($sformatf("vec%0d pend_hit", i), 32'(pend_hit), 32'(vecs[i].e_pend));
            check($sformatf("vec%0d fifo_count", i), 32'(fifo_count), 32'(vecs[i].e_cnt));
            check($sformatf("vec%0d stall_req", i), 32'(stall_req), 32'd0);
        end

        // ---------------- starvation: bubble taken ----------------
        @(negedge clk);
        set_in(0, 1, 1, 'h70, 1, 15, 'h44, 0, 0);
        #1 check("starve0 rf_waddr", 32'(rf_waddr), 32'd1);
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            set_in(0, 1, 2, 32'(k), 0, 0, 0, 0, 0);
            #1;
            check($sformatf("starve0 c%0d stall_req", k), 32'(stall_req), 32'd0);
            check($sformatf("starve0 c%0d rf_waddr", k), 32'(rf_waddr), 32'd2);
            check($sformatf("starve0 c%0d fifo_count", k), 32'(fifo_count), 32'd1);
        end
        @(negedge clk);
        set_in(0, 0, 0, 0, 0, 0, 0, 0, 0);
        #1;
        check("starve0 bubble stall_req", 32'(stall_req), 32'(FAIR));
        check("starve0 bubble rf_we", 32'(rf_we), 32'd1);
        check("starve0 bubble rf_waddr", 32'(rf_waddr), 32'd15);
        check("starve0 bubble rf_wdata", rf_wdata, 32'h44);
        @(negedge clk);
        #1;
        check("starve0 after stall_req", 32'(stall_req), 32'd0);
        check("starve0 after fifo_count", 32'(fifo_count), 32'd0);

        // ---------------- starvation: bubble ignored, count restarts ----------------
        @(negedge clk);
        set_in(0, 0, 0, 0, 1, 16, 'h66, 0, 0);
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            set_in(0, 1, 3, 32'(k), 0, 0, 0, 16, 0);
            #1;
            check($sformatf("starve1 c%0d stall_req", k), 32'(stall_req),
                  32'(FAIR && (k == 9 || k == 17)));
            check($sformatf("starve1 c%0d rf_waddr", k), 32'(rf_waddr), 32'd3);
            check($sformatf("starve1 c%0d pend_hit", k), 32'(pend_hit), 32'd1);
        end
        @(negedge clk);
        set_in(0, 0, 0, 0, 0, 0, 0, 0, 0);
        #1;
        check("starve1 drain rf_we", 32'(rf_we), 32'd1);
        check("starve1 drain rf_wdata", rf_wdata, 32'h66);

        // ---------------- randomized traffic vs queue model ----------------
        @(negedge clk);
        set_in(1, 0, 0, 0, 0, 0, 0, 0, 0);
        q.delete(); waits = 0; m_stall = 1'b0;
        begin
            int busy_pct;
            busy_pct = 50;
            for (int cyc = 0; cyc < 3000; cyc++) begin
                bit          a_req, popped, e_we, e_pend, e_brdy, nxt_stall;
                logic [4:0]  e_addr;
                logic [31:0] e_data;
                @(negedge clk);
                if (cyc % 64 == 0) busy_pct = ($urandom_range(0, 1) == 1) ? 97 : 40;
                set_in(1'($urandom_range(0, 99) == 0),
                       1'($urandom_range(0, 99) < busy_pct), 5'($urandom_range(0, 7)),
                       $urandom, 1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)),
                       $urandom, 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)));
                #1;
                a_req  = a_we && (a_waddr != 0);
                e_brdy = !rst && (q.size() < DEPTH);
                e_we = 0; e_addr = 0; e_data = 0; e_pend = 0;
                if (a_req) begin
                    e_we = 1; e_addr = a_waddr; e_data = a_wdata;
                end else if (q.size() > 0) begin
                    e_we = q[0].live; e_addr = q[0].addr; e_data = q[0].data;
                end
                foreach (q[i])
                    if (q[i].live && ((chk_addr1 != 0 && q[i].addr == chk_addr1) ||
                                      (chk_addr2 != 0 && q[i].addr == chk_addr2)))
                        e_pend = 1;
                if (rst) begin
                    check("rand rst rf_we", 32'(rf_we), 32'd0);
                    check("rand rst b_ready", 32'(b_ready), 32'd0);
                    check("rand rst pend_hit", 32'(pend_hit), 32'd0);
                    check("rand rst fifo_count", 32'(fifo_count), 32'd0);
                    check("rand rst stall_req", 32'(stall_req), 32'd0);
                    q.delete(); waits = 0; m_stall = 1'b0;
                end else begin
                    check("rand rf_we", 32'(rf_we), 32'(e_we));
                    check("rand rf_waddr", 32'(rf_waddr), 32'(e_addr));
                    check("rand rf_wdata", rf_wdata, e_data);
                    check("rand b_ready", 32'(b_ready), 32'(e_brdy));
                    check("rand pend_hit", 32'(pend_hit), 32'(e_pend));
                    check("rand fifo_count", 32'(fifo_count), 32'(q.size()));
                    check("rand stall_req", 32'(stall_req), 32'(m_stall));
                    popped    = !a_req && (q.size() > 0);
                    nxt_stall = 0;
                    if (FAIR && q.size() > 0 && !popped) begin
                        waits++;
                        if (waits == STARVE_LIMIT) begin
                            nxt_stall = 1;
                            waits     = 0;
                        end
                    end else begin
                        waits = 0;
                    end
                    m_stall = nxt_stall;
                    if (a_req)
                        foreach (q[i]) if (q[i].addr == a_waddr) q[i].live = 0;
                    if (popped) void'(q.pop_front());
                    if (b_valid && e_brdy && b_waddr != 0)
                        q.push_back('{addr: b_waddr, data: b_wdata, live: 1'b1});
                end
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
